unfilter_top: RTL and testbench



---
 rtl/unfilter_top.sv | 193 +++++++++++++++++++
 tb/tb_unfilter_top.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/unfilter_top.sv
// unfilter_top
// -----------------------------------------------------------------------------
// Reconstructs one PNG scanline per start_i by undoing the byte-wise PNG
// filter (None/Sub/Up/Average and, optionally, Paeth) on 4-byte RGBA pixels.
// Reconstructed pixels stream out one cycle after each accepted input beat.
// The previous reconstructed scanline is kept in an internal line buffer and
// supplies the "above" (b) and "above-left" (c) bytes for the predictors.
//
// Optional feature macro: UNFILTER_PAETH_EN
//   defined   -> Paeth predictor compiled in; filter type 4 is legal.
//   undefined -> no Paeth logic; type 4 is illegal (err_o set, line decoded
//                as None).
//
// Ports:
//   clk                in   clock
//   rstn               in   asynchronous active-low reset
//   cfg_w_i            in   pixels per scanline (1..LINE_DEPTH)
//   cfg_h_i            in   scanlines per image (>= 1)
//   start_i            in   one-cycle pulse that begins a scanline
//   done_o             out  one-cycle pulse with the last reconstructed pixel
//   err_o              out  sticky illegal-filter-type flag
//   val_i              in   input beat valid (first beat = filter type)
//   dat_i              in   filter type in [7:0], then filtered pixels
//   fifo_unf_wr_val_o  out  reconstructed pixel valid
//   fifo_unf_wr_dat_o  out  reconstructed pixel (R in the top byte)
// -----------------------------------------------------------------------------
module unfilter_top #(
    parameter int SIZE_W_WD   = 10,
    parameter int SIZE_H_WD   = 10,
    parameter int DATA_PXL_WD = 32,
    parameter int LINE_DEPTH  = 512
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [SIZE_W_WD-1:0]   cfg_w_i,
    input  logic [SIZE_H_WD-1:0]   cfg_h_i,
    input  logic                   start_i,
    output logic                   done_o,
    output logic                   err_o,
    input  logic                   val_i,
    input  logic [DATA_PXL_WD-1:0] dat_i,
    output logic                   fifo_unf_wr_val_o,
    output logic [DATA_PXL_WD-1:0] fifo_unf_wr_dat_o
);

    localparam int NB     = DATA_PXL_WD / 8;
    localparam int ADDR_W = $clog2(LINE_DEPTH);

    typedef enum logic [1:0] {IDLE, TYPE, DATA} state_e;

    state_e                 state_q;
    logic [SIZE_W_WD-1:0]   col_q;
    logic [SIZE_H_WD-1:0]   row_q;
    logic [2:0]             mode_q;
    logic                   err_q;
    logic                   done_q;
    logic                   val_q;
    logic [DATA_PXL_WD-1:0] dat_q;
    logic [DATA_PXL_WD-1:0] cPix_q;

    logic [DATA_PXL_WD-1:0] lineBuf [LINE_DEPTH];

    logic                   beat;
    logic                   lastCol;
    logic                   typeLegal;
    logic [ADDR_W-1:0]      addr;
    logic [DATA_PXL_WD-1:0] aPix;
    logic [DATA_PXL_WD-1:0] bPix;
    logic [DATA_PXL_WD-1:0] cPix;
    logic [DATA_PXL_WD-1:0] recon_d;

`ifdef UNFILTER_PAETH_EN
    // Paeth selection; pa/pb/pc are formed from the signed 10-bit estimate p.
    function automatic logic [7:0] paeth(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [7:0] c);
        logic signed [9:0] p, pa, pb, pc;
        p  = $signed({2'b00, a}) + $signed({2'b00, b}) - $signed({2'b00, c});
        pa = p - $signed({2'b00, a});
        pb = p - $signed({2'b00, b});
        pc = p - $signed({2'b00, c});
        if (pa < 0) pa = -pa;
        if (pb < 0) pb = -pb;
        if (pc < 0) pc = -pc;
        if (pa <= pb && pa <= pc) return a;
        else if (pb <= pc)        return b;
        else                      return c;
    endfunction
    assign typeLegal = (dat_i[7:0] <= 8'd4);
`else
    assign typeLegal = (dat_i[7:0] <= 8'd3);
`endif

    assign beat    = (state_q == DATA) && val_i;
    assign lastCol = (col_q == cfg_w_i - SIZE_W_WD'(1));
    assign addr    = col_q[ADDR_W-1:0];

    // a is the pixel just reconstructed, which is still held in the output
    // register. c cannot be read from the buffer because column x-1 already
    // holds this row's value, so the previous beat's b is kept in cPix_q.
    assign aPix = (col_q == '0) ? '0 : dat_q;
    assign bPix = (row_q == '0) ? '0 : lineBuf[addr];
    assign cPix = (col_q == '0 || row_q == '0) ? '0 : cPix_q;

    // Byte-wise reconstruction: Recon = Filt + predictor, mod 256 per byte.
    always_comb begin
        recon_d = '0;
        for (int k = 0; k < NB; k++) begin
            logic [7:0] a, b, c, f, pred;
            logic [8:0] sum;
            a    = aPix[8*k +: 8];
            b    = bPix[8*k +: 8];
            c    = cPix[8*k +: 8];
            f    = dat_i[8*k +: 8];
            sum  = {1'b0, a} + {1'b0, b};
            pred = 8'd0;
            case (mode_q)
                3'd1: pred = a;
                3'd2: pred = b;
                3'd3: pred = sum[8:1];
`ifdef UNFILTER_PAETH_EN
                3'd4: pred = paeth(a, b, c);
`endif
                default: pred = 8'd0;
            endcase
            recon_d[8*k +: 8] = f + pred;
        end
    end

    // Scanline control FSM with registered outputs. A start_i in the cycle
    // done_o is high is ignored so the next line begins one cycle later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            mode_q  <= 3'd0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            val_q   <= 1'b0;
            dat_q   <= '0;
            cPix_q  <= '0;
        end else begin
            done_q <= 1'b0;
            val_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i && !done_q) begin
                        state_q <= TYPE;
                        col_q   <= '0;
                        err_q   <= 1'b0;
                    end
                end
                TYPE: begin
                    if (val_i) begin
                        mode_q  <= typeLegal ? dat_i[2:0] : 3'd0;
                        err_q   <= !typeLegal;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (val_i) begin
                        val_q  <= 1'b1;
                        dat_q  <= recon_d;
                        cPix_q <= bPix;
                        col_q  <= col_q + SIZE_W_WD'(1);
                        if (lastCol) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                            col_q   <= '0;
                            row_q   <= (row_q == cfg_h_i - SIZE_H_WD'(1)) ?
                                       '0 : row_q + SIZE_H_WD'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Line buffer is intentionally not reset; row 0 masks its contents.
    always_ff @(posedge clk) begin
        if (beat) begin
            lineBuf[addr] <= recon_d;
        end
    end

    assign done_o            = done_q;
    assign err_o             = err_q;
    assign fifo_unf_wr_val_o = val_q;
    assign fifo_unf_wr_dat_o = dat_q;

endmodule

// File: tb/tb_unfilter_top.sv
// tb_unfilter_top
// -----------------------------------------------------------------------------
// Directed bench for unfilter_top: drives whole scanlines with hand-computed
// expected pixels and checks pixel values, count, done_o alignment, the
// one-cycle latency, err_o behaviour, row wrap and mid-line reset.
// -----------------------------------------------------------------------------
module tb_unfilter_top;

    logic        clk;
    logic        rstn;
    logic [9:0]  cfg_w_i;
    logic [9:0]  cfg_h_i;
    logic        start_i;
    logic        done_o;
    logic        err_o;
    logic        val_i;
    logic [31:0] dat_i;
    logic        fifo_unf_wr_val_o;
    logic [31:0] fifo_unf_wr_dat_o;

    int assertCnt = 0;
    int failCnt   = 0;

    logic [31:0] inPix  [8];
    logic [31:0] expPix [8];
    logic [31:0] outQ [$];
    int          doneCnt;
    int          doneWithVal;
    int          latErr;
    logic        tbDataPhase = 1'b0;
    logic        beatSeen    = 1'b0;

    unfilter_top dut (
        .clk               (clk),
        .rstn              (rstn),
        .cfg_w_i           (cfg_w_i),
        .cfg_h_i           (cfg_h_i),
        .start_i           (start_i),
        .done_o            (done_o),
        .err_o             (err_o),
        .val_i             (val_i),
        .dat_i             (dat_i),
        .fifo_unf_wr_val_o (fifo_unf_wr_val_o),
        .fifo_unf_wr_dat_o (fifo_unf_wr_dat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Remember whether a pixel beat was presented at this rising edge so the
    // following falling edge can confirm exactly one output appeared.
    always @(posedge clk) begin
        beatSeen = val_i && tbDataPhase;
    end

    // Collect outputs and done_o events away from the active edge.
    always @(negedge clk) begin
        if (fifo_unf_wr_val_o) outQ.push_back(fifo_unf_wr_dat_o);
        if (done_o) doneCnt++;
        if (done_o && fifo_unf_wr_val_o) doneWithVal++;
        if (fifo_unf_wr_val_o !== beatSeen) latErr++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCnt++;
        if (observed !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one scanline: start pulse, filter-type beat, w pixels with
    // deterministic gaps of up to gapMax idle cycles, then let it drain.
    task automatic applyStimulus(input logic [7:0] ftype, input int w, input int gapMax);
        outQ.delete();
        doneCnt     = 0;
        doneWithVal = 0;
        latErr      = 0;
        cfg_w_i     = 10'(w);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        val_i   = 1'b1;
        dat_i   = {24'h0, ftype};
        @(negedge clk);
        val_i       = 1'b0;
        tbDataPhase = 1'b1;
        for (int i = 0; i < w; i++) begin
            for (int g = 0; g < (i * 7 + 3) % (gapMax + 1); g++) @(negedge clk);
            val_i = 1'b1;
            dat_i = inPix[i];
            @(negedge clk);
            val_i = 1'b0;
        end
        tbDataPhase = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic checkLine(input string tag, input int w, input logic expErr);
        checkOutput({tag, "_count"}, 32'(outQ.size()), 32'(w));
        for (int i = 0; i < w && i < outQ.size(); i++)
            checkOutput($sformatf("%s_px%0d", tag, i), outQ[i], expPix[i]);
        checkOutput({tag, "_done"}, 32'(doneCnt), 32'd1);
        checkOutput({tag, "_doneAlign"}, 32'(doneWithVal), 32'd1);
        checkOutput({tag, "_latency"}, 32'(latErr), 32'd0);
        checkOutput({tag, "_err"}, {31'd0, err_o}, {31'd0, expErr});
    endtask

    task automatic setPix(input int i, input logic [31:0] inV, input logic [31:0] expV);
        inPix[i]  = inV;
        expPix[i] = expV;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rstn    = 1'b0;
        cfg_w_i = 10'd4;
        cfg_h_i = 10'd16;
        start_i = 1'b0;
        val_i   = 1'b0;
        dat_i   = 32'h0;
        repeat (3) @(negedge clk);
        checkOutput("rst_val",  {31'd0, fifo_unf_wr_val_o}, 32'd0);
        checkOutput("rst_dat",  fifo_unf_wr_dat_o, 32'd0);
        checkOutput("rst_done", {31'd0, done_o}, 32'd0);
        checkOutput("rst_err",  {31'd0, err_o}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // None on row 0: pass-through.
        setPix(0, 32'h01020304, 32'h01020304);
        setPix(1, 32'h05060708, 32'h05060708);
        setPix(2, 32'h090A0B0C, 32'h090A0B0C);
        setPix(3, 32'h0D0E0F10, 32'h0D0E0F10);
        applyStimulus(8'd0, 4, 0);
        checkLine("none", 4, 1'b0);

        // Sub accumulates left to right.
        setPix(0, 32'h01010101, 32'h01010101);
        setPix(1, 32'h01010101, 32'h02020202);
        setPix(2, 32'h01010101, 32'h03030303);
        applyStimulus(8'd1, 3, 0);
        checkLine("sub", 3, 1'b0);

        // Sub wraps per byte.
        setPix(0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        setPix(1, 32'hFFFFFFFF, 32'hFEFEFEFE);
        setPix(2, 32'hFFFFFFFF, 32'hFDFDFDFD);
        applyStimulus(8'd1, 3, 0);
        checkLine("subWrap", 3, 1'b0);

        // Up against a known previous row, back-to-back then with gaps.
        for (int i = 0; i < 4; i++) setPix(i, 32'h10203040, 32'h10203040);
        applyStimulus(8'd0, 4, 0);
        checkLine("prevRow", 4, 1'b0);
        for (int i = 0; i < 4; i++) setPix(i, 32'h01010101, 32'h11213141);
        applyStimulus(8'd2, 4, 0);
        checkLine("up", 4, 1'b0);
        for (int i = 0; i < 4; i++) setPix(i, 32'h10203040, 32'h10203040);
        applyStimulus(8'd0, 4, 0);
        checkLine("prevRow2", 4, 1'b0);
        for (int i = 0; i < 4; i++) setPix(i, 32'h01010101, 32'h11213141);
        applyStimulus(8'd2, 4, 3);
        checkLine("upGaps", 4, 1'b0);

        // Average: col0 a=0,b=60 -> 30+50=80; col1 a=80,b=40 -> 60.
        setPix(0, 32'h60606060, 32'h60606060);
        setPix(1, 32'h40404040, 32'h40404040);
        applyStimulus(8'd0, 2, 0);
        checkLine("prevAvg", 2, 1'b0);
        setPix(0, 32'h50505050, 32'h80808080);
        setPix(1, 32'h00000000, 32'h60606060);
        applyStimulus(8'd3, 2, 0);
        checkLine("avg", 2, 1'b0);

        // Paeth: col0 selects b (60); col1 a=80,b=40,c=60 selects c (60).
        setPix(0, 32'h60606060, 32'h60606060);
        setPix(1, 32'h40404040, 32'h40404040);
        applyStimulus(8'd0, 2, 0);
        checkLine("prevPaeth", 2, 1'b0);
`ifdef UNFILTER_PAETH_EN
        setPix(0, 32'h20202020, 32'h80808080);
        setPix(1, 32'h00000000, 32'h60606060);
        applyStimulus(8'd4, 2, 0);
        checkLine("paeth", 2, 1'b0);
`else
        setPix(0, 32'h20202020, 32'h20202020);
        setPix(1, 32'h00000000, 32'h00000000);
        applyStimulus(8'd4, 2, 0);
        checkLine("paethOff", 2, 1'b1);
`endif

        // Illegal type passes through and flags err_o; next start clears it.
        setPix(0, 32'h12345678, 32'h12345678);
        setPix(1, 32'h9ABCDEF0, 32'h9ABCDEF0);
        applyStimulus(8'd7, 2, 0);
        checkLine("type7", 2, 1'b1);
        setPix(0, 32'hAABBCCDD, 32'hAABBCCDD);
        applyStimulus(8'd0, 1, 0);
        checkLine("errClear", 1, 1'b0);

        // Row wrap with a two-row image.
        pulseReset();
        cfg_h_i = 10'd2;
        for (int i = 0; i < 2; i++) setPix(i, 32'h10203040, 32'h10203040);
        applyStimulus(8'd0, 2, 0);
        checkLine("h2row0", 2, 1'b0);
        for (int i = 0; i < 2; i++) setPix(i, 32'h01010101, 32'h11213141);
        applyStimulus(8'd2, 2, 0);
        checkLine("h2row1", 2, 1'b0);
        for (int i = 0; i < 2; i++) setPix(i, 32'h05050505, 32'h05050505);
        applyStimulus(8'd2, 2, 0);
        checkLine("h2wrap", 2, 1'b0);

        // Reset after 2 of 4 pixels, then an Up line must see row 0.
        cfg_w_i = 10'd4;
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        val_i   = 1'b1;
        dat_i   = 32'h0;
        @(negedge clk);
        tbDataPhase = 1'b1;
        dat_i = 32'h0A0A0A0A;
        @(negedge clk);
        dat_i = 32'h0B0B0B0B;
        @(negedge clk);
        val_i       = 1'b0;
        tbDataPhase = 1'b0;
        rstn        = 1'b0;
        #1;
        checkOutput("midRst_val", {31'd0, fifo_unf_wr_val_o}, 32'd0);
        checkOutput("midRst_dat", fifo_unf_wr_dat_o, 32'd0);
        checkOutput("midRst_done", {31'd0, done_o}, 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        setPix(0, 32'h07070707, 32'h07070707);
        setPix(1, 32'h08080808, 32'h08080808);
        applyStimulus(8'd2, 2, 0);
        checkLine("afterRst", 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
        $finish;
    end

endmodule
